// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^233) datapath: field degree, trinomial
// middle exponent, digit size, derived digit count, element type and the
// multiplier control states.
package gf2m_pkg;

  localparam int GF_M = 233;
  localparam int GF_K = 74;
  localparam int GF_D = 4;

  // Number of D-bit digits needed to cover an m-bit multiplier operand.
  function automatic int gf_ndig(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

  localparam int GF_NDIG = gf_ndig(GF_M, GF_D);

  typedef logic [GF_M-1:0] gf_elem_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gf_state_t;

endpackage

// File: rtl/gf2m_xd_reduce.sv
// One digit step of the MSB-first multiplier:
//   y = (acc * x^D  +  a * dig) mod f,   f = x^M + x^K + 1.
// Both terms are summed unreduced (degree <= M+D-1) and then share a single
// fold; one fold suffices because K+D-1 < M keeps the folded bits below M.
module gf2m_xd_reduce #(
  parameter int M = 233,
  parameter int K = 74,
  parameter int D = 4
) (
  input  logic [M-1:0] i_acc,
  input  logic [M-1:0] i_a,
  input  logic [D-1:0] i_dig,
  output logic [M-1:0] o_y
);

  localparam int W = M + D;

  logic [W-1:0] w_prod;
  logic [D-1:0] w_hi;

  // Unreduced sum of the shifted accumulator and the carry-less a*dig product,
  // followed by folding the top D bits to positions p-M and p-M+K.
  always_comb begin
    w_prod = {i_acc, {D{1'b0}}};
    for (int i = 0; i < D; i++) begin
      if (i_dig[i]) begin
        w_prod = w_prod ^ (W'(i_a) << i);
      end
    end
    w_hi = w_prod[W-1:M];
    o_y  = w_prod[M-1:0] ^ M'(w_hi) ^ (M'(w_hi) << K);
  end

endmodule

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier, MSB-first, polynomial basis.
// Latches a and b on an accepted start, consumes D bits of b per cycle for
// NDIG cycles, then presents c = a*b mod f with a one-cycle done pulse.
module gf2m_digit_mult
  import gf2m_pkg::*;
#(
  parameter int M = GF_M,
  parameter int K = GF_K,
  parameter int D = GF_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c
);

  localparam int NDIG = gf_ndig(M, D);
  localparam int BW   = NDIG * D;
  localparam int CW   = $clog2(NDIG + 1);

  gf_state_t        r_state;
  logic [M-1:0]     r_areg;
  logic [BW-1:0]    r_breg;
  logic [M-1:0]     r_acc;
  logic [CW-1:0]    r_cnt;
  logic [M-1:0]     r_c;
  logic             r_done;
  logic             r_busy;

  logic [D-1:0]     w_dig;
  logic [M-1:0]     w_next;

  // breg is shifted left each step, so the current digit is always its top D
  // bits; this walks the digits from most to least significant like cnt does.
  assign w_dig = r_breg[BW-1 -: D];

  gf2m_xd_reduce #(
    .M (M),
    .K (K),
    .D (D)
  ) u_step (
    .i_acc (r_acc),
    .i_a   (r_areg),
    .i_dig (w_dig),
    .o_y   (w_next)
  );

  // Control FSM and datapath registers; done is a single-cycle pulse and c only
  // changes on completion or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_areg  <= '0;
      r_breg  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_areg  <= a;
            r_breg  <= BW'(b);
            r_acc   <= '0;
            r_cnt   <= CW'(NDIG - 1);
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc  <= w_next;
          r_breg <= r_breg << D;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_cnt   <= '0;
            r_c     <= w_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign c    = r_c;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Directed and randomised checks of the digit-serial GF(2^233) multiplier
// against hand-derived products and a bit-serial reference model.
module tb_gf2m_digit_mult;
  import gf2m_pkg::*;

  localparam int M    = GF_M;
  localparam int NDIG = GF_NDIG;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] c;

  int total;
  int bad;

  gf2m_digit_mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [M-1:0] bitv(input int p);
    logic [M-1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
    return t[M-1:0];
  endfunction

  // Bit-serial MSB-first shift-and-add multiply with x^233 = x^74 + 1.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r;
    logic hi;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      hi = r[M-1];
      r  = r << 1;
      if (hi) begin
        r[0]  = r[0] ^ 1'b1;
        r[74] = r[74] ^ 1'b1;
      end
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents operands with start high so the next rising edge is E0; returns at E0+1.
  task automatic drive_start(input logic [M-1:0] av, input logic [M-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '1;
    b = '1;
    #3;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || c !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got busy=%b done=%b c=%h want 0/0/0", busy, done, c);
    end
    wait_edges(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(1);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_release got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_one_times_one();
    int busyErr;
    busyErr = 0;
    drive_start(bitv(0), bitv(0));
    for (int k = 1; k < NDIG; k++) begin
      wait_edges(1);
      if (busy !== 1'b1 || done !== 1'b0) busyErr++;
    end
    total++;
    if (busyErr != 0) begin
      bad++;
      $display("[TB] FAIL busy_window got %0d bad cycles want 0", busyErr);
    end
    wait_edges(1);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_at_E59 got done=%b busy=%b want 1/0", done, busy);
    end
    total++;
    if (c !== bitv(0)) begin
      bad++;
      $display("[TB] FAIL one_times_one got %h want %h", c, bitv(0));
    end
    wait_edges(1);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_pulse_E60 got %b want 0", done);
    end
    total++;
    if (c !== bitv(0)) begin
      bad++;
      $display("[TB] FAIL c_held_idle got %h want %h", c, bitv(0));
    end
  endtask

  task automatic test_directed();
    drive_start(bitv(232), bitv(1));
    wait_edges(NDIG);
    total++;
    if (done !== 1'b1 || c !== (bitv(74) | bitv(0))) begin
      bad++;
      $display("[TB] FAIL x232_times_x got done=%b c=%h want 1 %h", done, c, bitv(74) | bitv(0));
    end
    wait_edges(1);
    drive_start(bitv(232), bitv(232));
    wait_edges(NDIG);
    total++;
    if (done !== 1'b1 || c !== (bitv(231) | bitv(146) | bitv(72))) begin
      bad++;
      $display("[TB] FAIL x232_squared got done=%b c=%h want 1 %h", done, c, bitv(231) | bitv(146) | bitv(72));
    end
    wait_edges(1);
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] exp1;
    logic [M-1:0] exp2;
    exp1 = bitv(231) | bitv(146) | bitv(72);
    exp2 = bitv(74) | bitv(0);
    drive_start(bitv(232), bitv(232));
    wait_edges(9);
    start = 1'b1;
    a = '1;
    b = '1;
    wait_edges(1);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_while_busy got busy=%b done=%b want 1/0", busy, done);
    end
    wait_edges(2);
    start = 1'b0;
    wait_edges(46);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL no_early_done got %b want 0", done);
    end
    wait_edges(1);
    total++;
    if (done !== 1'b1 || c !== exp1) begin
      bad++;
      $display("[TB] FAIL ignored_restart got done=%b c=%h want 1 %h", done, c, exp1);
    end
    start = 1'b1;
    a = bitv(232);
    b = bitv(1);
    wait_edges(1);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL restart_E60 got done=%b busy=%b want 0/1", done, busy);
    end
    start = 1'b0;
    a = '1;
    b = '0;
    wait_edges(NDIG - 1);
    total++;
    if (done !== 1'b0 || c !== exp1) begin
      bad++;
      $display("[TB] FAIL c_held_E118 got done=%b c=%h want 0 %h", done, c, exp1);
    end
    wait_edges(1);
    total++;
    if (done !== 1'b1 || c !== exp2) begin
      bad++;
      $display("[TB] FAIL second_result_E119 got done=%b c=%h want 1 %h", done, c, exp2);
    end
    wait_edges(1);
  endtask

  task automatic test_reset_midrun();
    int doneSeen;
    doneSeen = 0;
    drive_start('1, '1);
    wait_edges(29);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || c !== '0) begin
      bad++;
      $display("[TB] FAIL reset_midrun got busy=%b done=%b c=%h want 0/0/0", busy, done, c);
    end
    wait_edges(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NDIG + 6; k++) begin
      wait_edges(1);
      if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
    end
    total++;
    if (doneSeen != 0) begin
      bad++;
      $display("[TB] FAIL aborted_no_done got %0d active cycles want 0", doneSeen);
    end
    drive_start(bitv(232), bitv(1));
    wait_edges(NDIG);
    total++;
    if (done !== 1'b1 || c !== (bitv(74) | bitv(0))) begin
      bad++;
      $display("[TB] FAIL op_after_reset got done=%b c=%h want 1 %h", done, c, bitv(74) | bitv(0));
    end
    wait_edges(1);
  endtask

  task automatic test_random();
    logic [M-1:0] av;
    logic [M-1:0] bv;
    logic [M-1:0] expv;
    for (int n = 0; n < 200; n++) begin
      av = rand_elem();
      bv = rand_elem();
      if (n == 0) av = '0;
      if (n == 1) bv = '0;
      if (n == 2) av = '1;
      if (n == 3) begin
        av = '1;
        bv = '1;
      end
      expv = ref_mul(av, bv);
      drive_start(av, bv);
      a = rand_elem();
      b = rand_elem();
      wait_edges(NDIG);
      total++;
      if (done !== 1'b1 || c !== expv) begin
        bad++;
        $display("[TB] FAIL random_%0d got done=%b c=%h want 1 %h", n, done, c, expv);
      end
      wait_edges(1);
    end
  endtask

  // Runs each scenario in order and prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_one_times_one();
    test_directed();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
